// File: rtl/ringnode_fifo.sv
// ringnode_fifo: slotted register-ring node with DEPTH-entry tx/rx FIFOs, NAK retry and optional broadcast.
// Latency: ring path fromring->toring is 1 clk; ring receive visible on rx_* 1 clk later; tx push seizable next cycle.
// Backpressure: tx_ready drops when the tx FIFO is full; ring slots addressed here pass untouched while rx is full.
//
// Optional feature macro: RINGNODE_BCAST_EN (DST all-ones becomes a broadcast address).
// Ports:
//   clk, rst               ring clock, asynchronous active-high reset
//   fromring / toring      upstream slot in, registered slot out to downstream
//   tx_data/valid/ready    client transmit port (valid/ready)
//   rx_data/valid/ready    client receive port (first-word fall-through head)
//   tx_level, rx_level     FIFO occupancy
//   txdrop                 1-clk pulse when a packet is dropped after MAX_RETRY attempts

// Generic FIFO: head is combinational from the read pointer, level tracks occupancy.
// Callers guarantee no push when full and no pop when empty.
module ringnode_fifo_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   level_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      level_q <= level_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  end

  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;
endmodule

module ringnode_fifo #(
  parameter int WIDTH     = 16,
  parameter int ABITS     = 3,
  parameter int ADDRESS   = 0,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       fromring,
  output logic [WIDTH-1:0]       toring,
  input  logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   txdrop
);
  localparam int FULL   = WIDTH - 1;
  localparam int ACK    = WIDTH - 2;
  localparam int DST_HI = ACK - 1;
  localparam int SRC_HI = ACK - ABITS - 1;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int RW     = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [ABITS-1:0] MY_ADDR  = ABITS'(ADDRESS);

  logic [WIDTH-1:0] toring_q, toring_d;
  logic             busy_q, busy_d;
  logic [RW-1:0]    retry_q, retry_d, retry_inc;
  logic             txdrop_q, txdrop_d;

  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic [WIDTH-1:0] tx_head, rx_head;

  logic [ABITS-1:0] slot_dst, slot_src;
  logic             is_pay, is_ack, is_free, is_bcast, own, rx_space;

  assign slot_dst = fromring[DST_HI -: ABITS];
  assign slot_src = fromring[SRC_HI -: ABITS];
  assign is_pay   = fromring[FULL];
  assign is_ack   = (fromring[FULL:ACK] == 2'b01);
  assign is_free  = (fromring[FULL:ACK] == 2'b00);
  // Only slots we launched while busy count as ours; a survivor from before reset is foreign.
  assign own      = busy_q && (slot_src == MY_ADDR);
  // Registered level only: a same-cycle client pop does not make room.
  assign rx_space = (rx_level != LVL_FULL);
  assign retry_inc = retry_q + 1'b1;

`ifdef RINGNODE_BCAST_EN
  assign is_bcast = is_pay && (slot_dst == {ABITS{1'b1}});
`else
  assign is_bcast = 1'b0;
`endif

  assign tx_ready = (tx_level != LVL_FULL);
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = (rx_level != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_valid ? rx_head : '0;

  // Ring rules are mutually exclusive and evaluated in priority order.
  always_comb begin
    toring_d = fromring;
    busy_d   = busy_q;
    retry_d  = retry_q;
    txdrop_d = 1'b0;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    if (is_pay && !is_bcast && slot_dst == MY_ADDR && rx_space) begin
      rx_push             = 1'b1;
      toring_d[FULL:ACK]  = 2'b01;
    end else if (is_bcast && slot_src != MY_ADDR && rx_space) begin
      rx_push = 1'b1;                       // copy and forward unchanged
    end else if (is_bcast && own) begin
      toring_d[FULL:ACK] = 2'b00;           // broadcast completed its lap
      tx_pop             = 1'b1;
      busy_d             = 1'b0;
      retry_d            = '0;
    end else if (is_pay && own) begin
      toring_d[FULL:ACK] = 2'b00;           // NAK: nobody accepted it
      busy_d             = 1'b0;
      if (retry_inc == RW'(MAX_RETRY)) begin
        tx_pop   = 1'b1;
        txdrop_d = 1'b1;
        retry_d  = '0;
      end else begin
        retry_d = retry_inc;
      end
    end else if (is_ack && own) begin
      toring_d[FULL:ACK] = 2'b00;
      tx_pop             = 1'b1;
      busy_d             = 1'b0;
      retry_d            = '0;
    end else if (is_free && !busy_q && tx_level != '0) begin
      toring_d                 = tx_head;
      toring_d[FULL:ACK]       = 2'b10;
      toring_d[SRC_HI -: ABITS] = MY_ADDR;
      busy_d                   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toring_q <= '0;
      busy_q   <= 1'b0;
      retry_q  <= '0;
      txdrop_q <= 1'b0;
    end else begin
      toring_q <= toring_d;
      busy_q   <= busy_d;
      retry_q  <= retry_d;
      txdrop_q <= txdrop_d;
    end
  end

  assign toring = toring_q;
  assign txdrop = txdrop_q;

  ringnode_fifo_buf #(.W(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push_i(tx_push), .din_i(tx_data),
    .pop_i(tx_pop), .head_o(tx_head), .level_o(tx_level)
  );

  ringnode_fifo_buf #(.W(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push_i(rx_push), .din_i(fromring),
    .pop_i(rx_pop), .head_o(rx_head), .level_o(rx_level)
  );
endmodule

// File: tb/tb_ringnode_fifo.sv
// Bench for ringnode_fifo (WIDTH=16, ABITS=3, ADDRESS=2, DEPTH=4, MAX_RETRY=3).
// Single-cycle ring vectors from a table, plus hand sequences for seize/ack, NAK retry,
// rx-full, tx-full and reset. Received packets are tracked in an expected-data queue.
module tb_ringnode_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fromring, toring, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, txdrop;
  logic [2:0]  tx_level, rx_level;

`ifdef RINGNODE_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam logic [15:0] IDLE = 16'hA155;  // foreign payload, passes straight through

  always #5 clk = ~clk;

  ringnode_fifo #(.WIDTH(16), .ABITS(3), .ADDRESS(2), .DEPTH(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .fromring(fromring), .toring(toring),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .txdrop(txdrop)
  );

  typedef struct {
    logic [15:0] fr;
    logic [15:0] exp;
    bit          push;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] rx_exp[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the rx FIFO through the client port, comparing against the expected queue.
  task automatic drain();
    rx_ready = 1'b1;
    for (int k = 0; k < 8 && rx_exp.size() > 0; k++) begin
      chk("drain rx_valid", rx_valid, 1);
      chk("drain rx_data", rx_data, rx_exp.pop_front());
      step();
    end
    rx_ready = 1'b0;
    chk("drain rx_level", rx_level, rx_exp.size());
    chk("drain rx_valid end", rx_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 1'b0};  // free slot, nothing to send
    vecs[1] = '{16'h9355, 16'h5355, 1'b1};  // addressed here
    vecs[2] = '{16'h5355, 16'h5355, 1'b0};  // foreign ack
    vecs[3] = '{16'h9A55, 16'h9A55, 1'b0};  // own SRC but not outstanding
    vecs[4] = '{16'hA155, 16'hA155, 1'b0};  // other destination
    vecs[5] = '{16'h9000, 16'h5000, 1'b1};  // addressed here, zero payload
    vecs[6] = '{16'hBB55, 16'hBB55, BC};    // all-ones DST
    vecs[7] = '{16'h4000, 16'h4000, 1'b0};  // ack from node 0
    vecs[8] = '{16'hD2AA, 16'h52AA, 1'b1};  // type 11 payload addressed here

    rst = 1'b1; fromring = '0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    step(); step();
    chk("reset toring", toring, 16'h0000);
    chk("reset tx_ready", tx_ready, 1);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset tx_level", tx_level, 0);
    chk("reset rx_level", rx_level, 0);
    chk("reset txdrop", txdrop, 0);
    rst = 1'b0; fromring = IDLE;
    step();

    // Table of single-cycle ring vectors from idle
    for (int i = 0; i < 9; i++) begin
      fromring = vecs[i].fr;
      step();
      if (vecs[i].push) rx_exp.push_back(vecs[i].fr);
      chk($sformatf("vec%0d toring", i), toring, vecs[i].exp);
      chk($sformatf("vec%0d rx_level", i), rx_level, rx_exp.size());
      chk($sformatf("vec%0d rx_valid", i), rx_valid, rx_exp.size() != 0);
    end
    fromring = IDLE;
    drain();

    // Seize, ack, then the next head goes out
    tx_valid = 1'b1; tx_data = 16'h1855; step();
    tx_data = 16'h2011; step();
    tx_valid = 1'b0;
    chk("tx two pushed", tx_level, 2);
    fromring = 16'h0000; step();
    chk("seize first", toring, 16'h9A55);
    chk("seize head kept", tx_level, 2);
    step();
    chk("busy no reseize", toring, 16'h0000);
    fromring = 16'h5A55; step();
    chk("ack frees slot", toring, 16'h1A55);
    chk("ack pops head", tx_level, 1);
    fromring = 16'h0000; step();
    chk("seize second", toring, 16'hA211);
    fromring = 16'h6211; step();
    chk("ack second", toring, 16'h2211);
    chk("tx empty", tx_level, 0);
    fromring = 16'h0000; step();
    chk("free passes", toring, 16'h0000);

    // NAK retries and drop
    tx_valid = 1'b1; tx_data = 16'h1855; fromring = IDLE; step();
    tx_valid = 1'b0;
    fromring = 16'h0000; step();
    chk("nak seize", toring, 16'h9A55);
    for (int k = 1; k <= 3; k++) begin
      fromring = 16'h9A55; step();
      chk($sformatf("nak%0d toring", k), toring, 16'h1A55);
      chk($sformatf("nak%0d txdrop", k), txdrop, k == 3);
      chk($sformatf("nak%0d tx_level", k), tx_level, (k == 3) ? 0 : 1);
      fromring = 16'h0000; step();
      chk($sformatf("nak%0d next free", k), toring, (k == 3) ? 16'h0000 : 16'h9A55);
      if (k == 3) chk("txdrop one cycle", txdrop, 0);
    end

    // rx full: ring slot addressed here passes unchanged
    rx_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      fromring = 16'h9300 | 16'(j);
      rx_exp.push_back(fromring);
      step();
      chk($sformatf("fill%0d toring", j), toring, 16'h5300 | 16'(j));
    end
    chk("rx full level", rx_level, 4);
    fromring = 16'h9355; step();
    chk("rx full forward", toring, 16'h9355);
    chk("rx full level kept", rx_level, 4);
    fromring = 16'hBB55; step();
    chk("rx full bcast", toring, 16'hBB55);
    // Pop while full: the same-cycle pop does not let the ring push in
    rx_ready = 1'b1; fromring = 16'h9377;
    chk("pop@full rx_data", rx_data, rx_exp.pop_front());
    step();
    chk("pop@full toring", toring, 16'h9377);
    chk("pop@full level", rx_level, 3);
    fromring = 16'h9388;
    chk("push+pop rx_data", rx_data, rx_exp.pop_front());
    rx_exp.push_back(16'h9388);
    step();
    chk("push+pop toring", toring, 16'h5388);
    chk("push+pop level", rx_level, 3);
    rx_ready = 1'b0; fromring = IDLE;
    drain();

    // tx full, then reset with a packet in flight
    tx_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tx_data = 16'h1800 | 16'(j);
      step();
    end
    chk("tx full ready", tx_ready, 0);
    tx_data = 16'h1899; step();
    chk("tx full level", tx_level, 4);
    tx_valid = 1'b0;
    fromring = 16'h0000; step();
    chk("full seize", toring, 16'h9A00);
    fromring = 16'h9311; step();
    rst = 1'b1; step();
    rx_exp.delete();
    chk("midrst toring", toring, 16'h0000);
    chk("midrst tx_ready", tx_ready, 1);
    chk("midrst tx_level", tx_level, 0);
    chk("midrst rx_level", rx_level, 0);
    chk("midrst rx_valid", rx_valid, 0);
    chk("midrst rx_data", rx_data, 0);
    chk("midrst txdrop", txdrop, 0);
    rst = 1'b0; fromring = 16'h9A00; step();
    chk("not readopted", toring, 16'h9A00);
    chk("not readopted lvl", tx_level, 0);

    // All-ones destination returning to its sender
    tx_valid = 1'b1; tx_data = 16'h3855; fromring = IDLE; step();
    tx_valid = 1'b0;
    fromring = 16'h0000; step();
    chk("bcast seize", toring, 16'hBA55);
    fromring = 16'hBA55; step();
    chk("bcast return toring", toring, 16'h3A55);
    chk("bcast return level", tx_level, BC ? 0 : 1);
    chk("bcast return txdrop", txdrop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
